// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch and loader share one synchronous-read port.
// Optional loader anti-starvation ageing is enabled with `define IMEM_ARB_AGE_EN.
module imem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    input  logic              flush,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] RSP_NONE      = 2'd0;
    localparam logic [1:0] RSP_FETCH     = 2'd1;
    localparam logic [1:0] RSP_FETCH_ERR = 2'd2;
    localparam logic [1:0] RSP_LOAD      = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]        rsp_q, rsp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              f_take;
    logic              f_range_err;
    logic              rsp_is_fetch;

    assign f_range_err = (f_addr[31:ADDR_W+2] != '0) || (f_addr[1:0] != 2'b00);

`ifdef IMEM_ARB_AGE_EN
    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

    logic [AGE_W-1:0] age_q, age_d;

    // Saturated age hands the loader exactly one grant ahead of fetch.
    assign f_take = f_req & ~reset & (age_q != AGE_MAX);

    always_comb begin
        age_d = age_q;
        if (!l_req || l_gnt) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign f_take = f_req & ~reset;
`endif

    assign f_gnt = f_take;
    assign l_gnt = l_req & ~reset & ~f_take;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rsp_d     = RSP_NONE;
        if (f_take) begin
            if (f_range_err) begin
                rsp_d = RSP_FETCH_ERR;
            end else begin
                mem_en = 1'b1;
                addr_d = f_addr[ADDR_W+1:2];
                rsp_d  = RSP_FETCH;
            end
        end else if (l_gnt) begin
            mem_en  = 1'b1;
            mem_we  = l_we;
            addr_d  = l_addr;
            wdata_d = l_wdata;
            rsp_d   = l_we ? RSP_NONE : RSP_LOAD;
        end
    end

    // Port address/data are driven straight through while granting and held otherwise.
    assign mem_addr  = addr_d;
    assign mem_wdata = wdata_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_q   <= RSP_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            rsp_q   <= rsp_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Flush masks only the response already in flight; the flush-cycle fetch proceeds.
    assign rsp_is_fetch = ((rsp_q == RSP_FETCH) || (rsp_q == RSP_FETCH_ERR)) && !flush;

    assign f_rvalid = rsp_is_fetch;
    assign f_err    = rsp_is_fetch && (rsp_q == RSP_FETCH_ERR);
    assign f_rdata  = !rsp_is_fetch         ? '0  :
                      (rsp_q == RSP_FETCH_ERR) ? NOP : mem_rdata;

    assign l_rvalid = (rsp_q == RSP_LOAD);
    assign l_rdata  = l_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural 1024-word memory.
// Starvation expectations follow `define IMEM_ARB_AGE_EN when it is set.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, flush, l_req, l_we;
    logic [31:0] f_addr, l_wdata;
    logic [9:0]  l_addr;
    logic        f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, mem_en, mem_we;
    logic [31:0] f_rdata, l_rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;

    logic [31:0] mem [0:1023];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    imem_arbiter #(.ADDR_W(10), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err), .flush(flush),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(negedge clk);
        f_req = 1'b0; l_req = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; f_req = 0; f_addr = 0; flush = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({f_rvalid, l_rvalid, f_err, mem_en, mem_we, f_gnt, l_gnt} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags got %b exp 0", {f_rvalid, l_rvalid, f_err, mem_en, mem_we, f_gnt, l_gnt});
        end
        n_tests++;
        if ({f_rdata, l_rdata, mem_wdata, mem_addr} !== '0) begin
            n_fail++; $display("FAIL reset_data got %h %h %h %h exp 0", f_rdata, l_rdata, mem_wdata, mem_addr);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        step(); f_req = 1; f_addr = 32'h4; #1;
        n_tests++;
        if ({f_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 10'd1}) begin
            n_fail++; $display("FAIL fetch_issue got gnt=%b en=%b we=%b addr=%0d exp 1 1 0 1", f_gnt, mem_en, mem_we, mem_addr);
        end
        step(); #1;
        n_tests++;
        if ({f_rvalid, f_err, f_rdata} !== {1'b1, 1'b0, 32'hA000_0001}) begin
            n_fail++; $display("FAIL fetch_resp got v=%b e=%b d=%h exp 1 0 a0000001", f_rvalid, f_err, f_rdata);
        end
        n_tests++;
        if ({mem_en, mem_addr} !== {1'b0, 10'd1}) begin
            n_fail++; $display("FAIL idle_hold got en=%b addr=%0d exp 0 1", mem_en, mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hA000_0000; exp_d[1] = 32'hA000_0001; exp_d[2] = 32'hA000_0002;
        step(); f_req = 1; f_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i < 2) begin f_req = 1; f_addr = 32'(4 * (i + 1)); end
            #1;
            n_tests++;
            if ({f_rvalid, f_rdata} !== {1'b1, exp_d[i]}) begin
                n_fail++; $display("FAIL b2b_%0d got v=%b d=%h exp 1 %h", i, f_rvalid, f_rdata, exp_d[i]);
            end
        end
    endtask

    task automatic test_loader();
        step(); l_req = 1; l_we = 1; l_addr = 10'd5; l_wdata = 32'hDEADBEEF; #1;
        n_tests++;
        if ({l_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd5, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL ld_write got gnt=%b en=%b we=%b a=%0d d=%h exp 1 1 1 5 deadbeef", l_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        step(); l_req = 1; l_we = 0; l_addr = 10'd5; #1;
        n_tests++;
        if ({l_gnt, mem_we, l_rvalid} !== 3'b100) begin
            n_fail++; $display("FAIL ld_read_issue got gnt=%b we=%b rv=%b exp 1 0 0", l_gnt, mem_we, l_rvalid);
        end
        step(); flush = 1; #1;
        n_tests++;
        if ({l_rvalid, l_rdata, f_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            n_fail++; $display("FAIL ld_read_resp got rv=%b d=%h frv=%b exp 1 deadbeef 0", l_rvalid, l_rdata, f_rvalid);
        end
    endtask

    task automatic test_range();
        logic [31:0] bad [2];
        bad[0] = 32'h1000; bad[1] = 32'h2;
        for (int i = 0; i < 2; i++) begin
            step(); f_req = 1; f_addr = bad[i]; #1;
            n_tests++;
            if ({f_gnt, mem_en} !== 2'b10) begin
                n_fail++; $display("FAIL range_issue_%0d got gnt=%b en=%b exp 1 0", i, f_gnt, mem_en);
            end
            step(); #1;
            n_tests++;
            if ({f_rvalid, f_err, f_rdata} !== {2'b11, 32'h0000_0013}) begin
                n_fail++; $display("FAIL range_resp_%0d got v=%b e=%b d=%h exp 1 1 00000013", i, f_rvalid, f_err, f_rdata);
            end
        end
    endtask

    task automatic test_flush();
        step(); f_req = 1; f_addr = 32'h0;
        step(); f_req = 1; f_addr = 32'h8; flush = 1; #1;
        n_tests++;
        if ({f_gnt, f_rvalid, f_rdata} !== {2'b10, 32'h0}) begin
            n_fail++; $display("FAIL flush_cancel got gnt=%b v=%b d=%h exp 1 0 0", f_gnt, f_rvalid, f_rdata);
        end
        step(); #1;
        n_tests++;
        if ({f_rvalid, f_rdata} !== {1'b1, 32'hA000_0002}) begin
            n_fail++; $display("FAIL flush_target got v=%b d=%h exp 1 a0000002", f_rvalid, f_rdata);
        end
    endtask

    task automatic test_starvation();
        step();
`ifdef IMEM_ARB_AGE_EN
        for (int c = 1; c <= 9; c++) begin
            f_req = 1; f_addr = 32'h0; l_req = 1; l_we = 0; l_addr = 10'd3; #1;
            n_tests++;
            if ({l_gnt, f_gnt} !== ((c == 9) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL age_cycle_%0d got lgnt=%b fgnt=%b", c, l_gnt, f_gnt);
            end
            step();
        end
`else
        for (int c = 1; c <= 20; c++) begin
            f_req = 1; f_addr = 32'h0; l_req = 1; l_we = 0; l_addr = 10'd3; #1;
            n_tests++;
            if ({l_gnt, f_gnt} !== 2'b01) begin
                n_fail++; $display("FAIL starve_cycle_%0d got lgnt=%b fgnt=%b exp 0 1", c, l_gnt, f_gnt);
            end
            step();
        end
`endif
        step();
    endtask

    task automatic test_reset_mid();
        step(); l_req = 1; l_we = 0; l_addr = 10'd5; #1;
        n_tests++;
        if (l_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_gnt got %b exp 1", l_gnt);
        end
        step(); reset = 1; #1;
        n_tests++;
        if ({l_rvalid, f_rvalid, f_err, mem_en, mem_we, l_rdata, f_rdata, mem_addr, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs got lrv=%b d=%h addr=%0d wd=%h exp 0", l_rvalid, l_rdata, mem_addr, mem_wdata);
        end
        step(); reset = 0; #1;
        n_tests++;
        if (l_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_no_rvalid got %b exp 0", l_rvalid);
        end
        step(); f_req = 1; f_addr = 32'h8; #1;
        n_tests++;
        if ({f_gnt, mem_en, mem_addr} !== {2'b11, 10'd2}) begin
            n_fail++; $display("FAIL rst_mid_fetch got gnt=%b en=%b a=%0d exp 1 1 2", f_gnt, mem_en, mem_addr);
        end
        step(); #1;
        n_tests++;
        if ({f_rvalid, f_rdata} !== {1'b1, 32'hA000_0002}) begin
            n_fail++; $display("FAIL rst_mid_resp got v=%b d=%h exp 1 a0000002", f_rvalid, f_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem_rdata = '0;
        test_reset();
        test_fetch();
        test_back_to_back();
        test_loader();
        test_range();
        test_flush();
        test_starvation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without finishing");
        $fatal(1);
    end

endmodule
